// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered RV32I decode stage with output FIFO; DECODE_RV32M_EN adds RV32M ops
package decode_pkg;
    localparam int DCODE_WIDTH = 6;
    typedef logic [DCODE_WIDTH-1:0] dcode_t;

    // ADDI is code 0 so an all-zero head entry reads as the idle/illegal default.
    localparam dcode_t DCODED_ADDI  = 6'd0;
    localparam dcode_t DCODED_SLTI  = 6'd1;
    localparam dcode_t DCODED_SLTIU = 6'd2;
    localparam dcode_t DCODED_XORI  = 6'd3;
    localparam dcode_t DCODED_ORI   = 6'd4;
    localparam dcode_t DCODED_ANDI  = 6'd5;
    localparam dcode_t DCODED_SLLI  = 6'd6;
    localparam dcode_t DCODED_SRLI  = 6'd7;
    localparam dcode_t DCODED_SRAI  = 6'd8;
    localparam dcode_t DCODED_ADD   = 6'd9;
    localparam dcode_t DCODED_SUB   = 6'd10;
    localparam dcode_t DCODED_SLL   = 6'd11;
    localparam dcode_t DCODED_SLT   = 6'd12;
    localparam dcode_t DCODED_SLTU  = 6'd13;
    localparam dcode_t DCODED_XOR   = 6'd14;
    localparam dcode_t DCODED_SRL   = 6'd15;
    localparam dcode_t DCODED_SRA   = 6'd16;
    localparam dcode_t DCODED_OR    = 6'd17;
    localparam dcode_t DCODED_AND   = 6'd18;
    localparam dcode_t DCODED_LB    = 6'd19;
    localparam dcode_t DCODED_LH    = 6'd20;
    localparam dcode_t DCODED_LW    = 6'd21;
    localparam dcode_t DCODED_LBU   = 6'd22;
    localparam dcode_t DCODED_LHU   = 6'd23;
    localparam dcode_t DCODED_SB    = 6'd24;
    localparam dcode_t DCODED_SH    = 6'd25;
    localparam dcode_t DCODED_SW    = 6'd26;
    localparam dcode_t DCODED_BEQ   = 6'd27;
    localparam dcode_t DCODED_BNE   = 6'd28;
    localparam dcode_t DCODED_BLT   = 6'd29;
    localparam dcode_t DCODED_BGE   = 6'd30;
    localparam dcode_t DCODED_BLTU  = 6'd31;
    localparam dcode_t DCODED_BGEU  = 6'd32;
    localparam dcode_t DCODED_JALR  = 6'd33;
    localparam dcode_t DCODED_JAL   = 6'd34;
    localparam dcode_t DCODED_AUIPC = 6'd35;
    localparam dcode_t DCODED_LUI   = 6'd36;
`ifdef DECODE_RV32M_EN
    localparam dcode_t DCODED_MUL    = 6'd37;
    localparam dcode_t DCODED_MULH   = 6'd38;
    localparam dcode_t DCODED_MULHSU = 6'd39;
    localparam dcode_t DCODED_MULHU  = 6'd40;
    localparam dcode_t DCODED_DIV    = 6'd41;
    localparam dcode_t DCODED_DIVU   = 6'd42;
    localparam dcode_t DCODED_REM    = 6'd43;
    localparam dcode_t DCODED_REMU   = 6'd44;
`endif
endpackage

module decode_stage #(
    parameter int WORD_WIDTH     = 32,
    parameter int DCODE_WIDTH    = decode_pkg::DCODE_WIDTH,
    parameter int DEPTH          = 2,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          flush_i,
    input  logic [WORD_WIDTH-1:0]         instr_i,
    input  logic                          instr_valid_i,
    output logic                          instr_ready_o,
    output logic [DCODE_WIDTH-1:0]        decoded_op_o,
    output logic [REG_ADDR_WIDTH-1:0]     rd_o,
    output logic [REG_ADDR_WIDTH-1:0]     rs1_o,
    output logic [REG_ADDR_WIDTH-1:0]     rs2_o,
    output logic [WORD_WIDTH-1:0]         imm_o,
    output logic                          illegal_o,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [$clog2(DEPTH):0]        count_o
);
    import decode_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OPC_COMP    = 7'b0110011;
    localparam logic [6:0] OPC_COMPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;

    typedef struct packed {
        dcode_t                    op;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [WORD_WIDTH-1:0]     imm;
        logic                      illegal;
    } entry_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    dcode_t     dec_op;
    logic [WORD_WIDTH-1:0] dec_imm;
    logic       dec_bad;
    entry_t     dec_entry;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        dec_op  = DCODED_ADDI;
        dec_imm = '0;
        dec_bad = 1'b0;
        case (opcode)
            OPC_COMP: begin
                if (funct7 == 7'h00) begin
                    case (funct3)
                        3'b000: dec_op = DCODED_ADD;
                        3'b001: dec_op = DCODED_SLL;
                        3'b010: dec_op = DCODED_SLT;
                        3'b011: dec_op = DCODED_SLTU;
                        3'b100: dec_op = DCODED_XOR;
                        3'b101: dec_op = DCODED_SRL;
                        3'b110: dec_op = DCODED_OR;
                        3'b111: dec_op = DCODED_AND;
                    endcase
                end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
                    dec_op = DCODED_SUB;
                end else if (funct7 == 7'h20 && funct3 == 3'b101) begin
                    dec_op = DCODED_SRA;
`ifdef DECODE_RV32M_EN
                end else if (funct7 == 7'h01) begin
                    case (funct3)
                        3'b000: dec_op = DCODED_MUL;
                        3'b001: dec_op = DCODED_MULH;
                        3'b010: dec_op = DCODED_MULHSU;
                        3'b011: dec_op = DCODED_MULHU;
                        3'b100: dec_op = DCODED_DIV;
                        3'b101: dec_op = DCODED_DIVU;
                        3'b110: dec_op = DCODED_REM;
                        3'b111: dec_op = DCODED_REMU;
                    endcase
`endif
                end else begin
                    dec_bad = 1'b1;
                end
            end
            OPC_COMPIMM: begin
                // Shift immediates keep the raw I-type field, funct7 bits included.
                dec_imm = WORD_WIDTH'($signed(instr_i[31:20]));
                case (funct3)
                    3'b000: dec_op = DCODED_ADDI;
                    3'b010: dec_op = DCODED_SLTI;
                    3'b011: dec_op = DCODED_SLTIU;
                    3'b100: dec_op = DCODED_XORI;
                    3'b110: dec_op = DCODED_ORI;
                    3'b111: dec_op = DCODED_ANDI;
                    3'b001: begin
                        dec_op  = DCODED_SLLI;
                        dec_bad = (funct7 != 7'h00);
                    end
                    3'b101: begin
                        dec_op  = (funct7 == 7'h20) ? DCODED_SRAI : DCODED_SRLI;
                        dec_bad = (funct7 != 7'h00) && (funct7 != 7'h20);
                    end
                endcase
            end
            OPC_LOAD: begin
                dec_imm = WORD_WIDTH'($signed(instr_i[31:20]));
                case (funct3)
                    3'b000:  dec_op = DCODED_LB;
                    3'b001:  dec_op = DCODED_LH;
                    3'b010:  dec_op = DCODED_LW;
                    3'b100:  dec_op = DCODED_LBU;
                    3'b101:  dec_op = DCODED_LHU;
                    default: dec_bad = 1'b1;
                endcase
            end
            OPC_STORE: begin
                dec_imm = WORD_WIDTH'($signed({instr_i[31:25], instr_i[11:7]}));
                case (funct3)
                    3'b000:  dec_op = DCODED_SB;
                    3'b001:  dec_op = DCODED_SH;
                    3'b010:  dec_op = DCODED_SW;
                    default: dec_bad = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                dec_imm = WORD_WIDTH'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                               instr_i[11:8], 1'b0}));
                case (funct3)
                    3'b000:  dec_op = DCODED_BEQ;
                    3'b001:  dec_op = DCODED_BNE;
                    3'b100:  dec_op = DCODED_BLT;
                    3'b101:  dec_op = DCODED_BGE;
                    3'b110:  dec_op = DCODED_BLTU;
                    3'b111:  dec_op = DCODED_BGEU;
                    default: dec_bad = 1'b1;
                endcase
            end
            OPC_JALR: begin
                dec_op  = DCODED_JALR;
                dec_imm = WORD_WIDTH'($signed(instr_i[31:20]));
                dec_bad = (funct3 != 3'b000);
            end
            OPC_JAL: begin
                dec_op  = DCODED_JAL;
                dec_imm = WORD_WIDTH'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                               instr_i[30:21], 1'b0}));
            end
            OPC_AUIPC: begin
                dec_op  = DCODED_AUIPC;
                dec_imm = WORD_WIDTH'($signed({instr_i[31:12], 12'b0}));
            end
            OPC_LUI: begin
                dec_op  = DCODED_LUI;
                dec_imm = WORD_WIDTH'($signed({instr_i[31:12], 12'b0}));
            end
            default: dec_bad = 1'b1;
        endcase

        dec_entry.op      = dec_bad ? DCODED_ADDI : dec_op;
        dec_entry.imm     = dec_bad ? '0 : dec_imm;
        dec_entry.illegal = dec_bad;
        dec_entry.rd      = REG_ADDR_WIDTH'(instr_i[11:7]);
        dec_entry.rs1     = REG_ADDR_WIDTH'(instr_i[19:15]);
        dec_entry.rs2     = REG_ADDR_WIDTH'(instr_i[24:20]);
    end

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    entry_t        head;

    assign out_valid_o   = (count != '0);
    assign instr_ready_o = (count != CW'(DEPTH)) || out_ready_i;
    assign push          = instr_valid_i && instr_ready_o;
    assign pop           = out_valid_o && out_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // When full, the write slot equals the slot being popped this same edge.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) mem[wr_ptr] <= dec_entry;
    end

    assign head         = out_valid_o ? mem[rd_ptr] : '0;
    assign decoded_op_o = DCODE_WIDTH'(head.op);
    assign rd_o         = head.rd;
    assign rs1_o        = head.rs1;
    assign rs2_o        = head.rs2;
    assign imm_o        = head.imm;
    assign illegal_o    = head.illegal;
    assign count_o      = count;
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage against a queue/table model
module tb_decode_stage;
    import decode_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [5:0]  decoded_op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        illegal;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  count;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    decode_stage #(.WORD_WIDTH(32), .DCODE_WIDTH(6), .DEPTH(DEPTH), .REG_ADDR_WIDTH(5)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .instr_i(instr),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .decoded_op_o(decoded_op), .rd_o(rd), .rs1_o(rs1), .rs2_o(rs2), .imm_o(imm),
        .illegal_o(illegal), .out_valid_o(out_valid), .out_ready_i(out_ready), .count_o(count)
    );

    typedef struct {
        dcode_t      op;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic        ill;
    } exp_t;

    exp_t q[$];

    localparam dcode_t R_OPS  [8] = '{DCODED_ADD, DCODED_SLL, DCODED_SLT, DCODED_SLTU,
                                      DCODED_XOR, DCODED_SRL, DCODED_OR, DCODED_AND};
    localparam dcode_t I_OPS  [8] = '{DCODED_ADDI, DCODED_SLLI, DCODED_SLTI, DCODED_SLTIU,
                                      DCODED_XORI, DCODED_SRLI, DCODED_ORI, DCODED_ANDI};
    localparam dcode_t LD_OPS [8] = '{DCODED_LB, DCODED_LH, DCODED_LW, DCODED_ADDI,
                                      DCODED_LBU, DCODED_LHU, DCODED_ADDI, DCODED_ADDI};
    localparam dcode_t ST_OPS [8] = '{DCODED_SB, DCODED_SH, DCODED_SW, DCODED_ADDI,
                                      DCODED_ADDI, DCODED_ADDI, DCODED_ADDI, DCODED_ADDI};
    localparam dcode_t BR_OPS [8] = '{DCODED_BEQ, DCODED_BNE, DCODED_ADDI, DCODED_ADDI,
                                      DCODED_BLT, DCODED_BGE, DCODED_BLTU, DCODED_BGEU};
`ifdef DECODE_RV32M_EN
    localparam dcode_t M_OPS  [8] = '{DCODED_MUL, DCODED_MULH, DCODED_MULHSU, DCODED_MULHU,
                                      DCODED_DIV, DCODED_DIVU, DCODED_REM, DCODED_REMU};
`endif
    localparam logic [7:0] LD_OK = 8'b0011_0111;
    localparam logic [7:0] ST_OK = 8'b0000_0111;
    localparam logic [7:0] BR_OK = 8'b1111_0011;

    function automatic exp_t model_decode(input logic [31:0] w);
        exp_t        e;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ok;
        dcode_t      op;
        logic [31:0] im;
        f3 = w[14:12];
        f7 = w[31:25];
        ok = 1'b1;
        op = DCODED_ADDI;
        im = 32'd0;
        case (w[6:0])
            7'h33: begin
                if (f7 == 7'h00) op = R_OPS[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) op = DCODED_SUB;
                else if (f7 == 7'h20 && f3 == 3'd5) op = DCODED_SRA;
`ifdef DECODE_RV32M_EN
                else if (f7 == 7'h01) op = M_OPS[f3];
`endif
                else ok = 1'b0;
            end
            7'h13: begin
                op = I_OPS[f3];
                im = 32'($signed(w[31:20]));
                if (f3 == 3'd1) ok = (f7 == 7'h00);
                if (f3 == 3'd5) begin
                    ok = (f7 == 7'h00) || (f7 == 7'h20);
                    if (f7 == 7'h20) op = DCODED_SRAI;
                end
            end
            7'h03: begin op = LD_OPS[f3]; ok = LD_OK[f3]; im = 32'($signed(w[31:20])); end
            7'h23: begin op = ST_OPS[f3]; ok = ST_OK[f3]; im = 32'($signed({w[31:25], w[11:7]})); end
            7'h63: begin
                op = BR_OPS[f3]; ok = BR_OK[f3];
                im = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
            end
            7'h67: begin op = DCODED_JALR; ok = (f3 == 3'd0); im = 32'($signed(w[31:20])); end
            7'h6F: begin op = DCODED_JAL; im = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); end
            7'h17: begin op = DCODED_AUIPC; im = {w[31:12], 12'h000}; end
            7'h37: begin op = DCODED_LUI; im = {w[31:12], 12'h000}; end
            default: ok = 1'b0;
        endcase
        e.op  = ok ? op : DCODED_ADDI;
        e.imm = ok ? im : 32'd0;
        e.ill = !ok;
        e.rd  = w[11:7];
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge rst_n) q.delete();

    always @(posedge clk) begin
        if (rst_n) begin
            logic m_pop, m_push;
            m_pop  = (q.size() != 0) && out_ready;
            m_push = instr_valid && ((q.size() < DEPTH) || out_ready);
            if (flush) begin
                q.delete();
            end else begin
                if (m_pop) void'(q.pop_front());
                if (m_push) q.push_back(model_decode(instr));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("cmp_count", 64'(count), 64'(q.size()));
            check("cmp_valid", 64'(out_valid), 64'(q.size() != 0));
            check("cmp_ready", 64'(instr_ready), 64'((q.size() < DEPTH) || out_ready));
            if (q.size() != 0) begin
                check("cmp_op",  64'(decoded_op), 64'(q[0].op));
                check("cmp_rd",  64'(rd),  64'(q[0].rd));
                check("cmp_rs1", 64'(rs1), 64'(q[0].rs1));
                check("cmp_rs2", 64'(rs2), 64'(q[0].rs2));
                check("cmp_imm", 64'(imm), 64'(q[0].imm));
                check("cmp_ill", 64'(illegal), 64'(q[0].ill));
            end else begin
                check("idle_op",  64'(decoded_op), 64'(DCODED_ADDI));
                check("idle_imm", 64'(imm), 64'd0);
                check("idle_ill", 64'(illegal), 64'd0);
            end
        end
    end

    task automatic cyc(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
        instr_valid = v;
        instr       = w;
        out_ready   = ordy;
        flush       = fl;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] stream [4] = '{32'h00C5F533, 32'h00412083, 32'h00001117, 32'h4030D093};
    logic [31:0] mixed [18] = '{32'h00513023, 32'h00413083, 32'h40309093, 32'h000090E7,
                               32'h00000073, 32'h0000000F, 32'h002081B2, 32'h0000A063,
                               32'h2030D093, 32'h402091B3, 32'hFE000EE3, 32'h000080E7,
                               32'h00309093, 32'h00412083, 32'h00C5F533, 32'h123450B7,
                               32'h008000EF, 32'h00512023};
    exp_t pin;

    initial begin
        pin = model_decode(32'hFFF00093);
        check("pin_addi_imm", 64'(pin.imm), 64'hFFFF_FFFF);
        pin = model_decode(32'h402081B3);
        check("pin_sub_op", 64'(pin.op), 64'(DCODED_SUB));
        pin = model_decode(32'hFE000EE3);
        check("pin_beq_imm", 64'(pin.imm), 64'hFFFF_FFFC);
        pin = model_decode(32'h008000EF);
        check("pin_jal_imm", 64'(pin.imm), 64'd8);
        pin = model_decode(32'h123450B7);
        check("pin_lui_imm", 64'(pin.imm), 64'h1234_5000);
        pin = model_decode(32'h00000073);
        check("pin_system_ill", 64'(pin.ill), 64'd1);

        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ready", 64'(instr_ready), 64'd1);
        check("rst_op", 64'(decoded_op), 64'(DCODED_ADDI));
        check("rst_ill", 64'(illegal), 64'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        cyc(1, 32'h002081B3, 0, 0);
        check("add_valid", 64'(out_valid), 64'd1);
        check("add_op", 64'(decoded_op), 64'(DCODED_ADD));
        check("add_rd", 64'(rd), 64'd3);
        check("add_rs1", 64'(rs1), 64'd1);
        check("add_rs2", 64'(rs2), 64'd2);
        check("add_imm", 64'(imm), 64'd0);
        check("add_ill", 64'(illegal), 64'd0);
        cyc(0, 0, 1, 0);
        check("add_drained", 64'(count), 64'd0);

        cyc(1, 32'hFFF00093, 0, 0);
        cyc(1, 32'h402081B3, 0, 0);
        check("full_count", 64'(count), 64'd2);
        check("full_ready", 64'(instr_ready), 64'd0);
        check("full_head_op", 64'(decoded_op), 64'(DCODED_ADDI));
        check("full_head_imm", 64'(imm), 64'hFFFF_FFFF);
        cyc(0, 0, 1, 0);
        check("sub_op", 64'(decoded_op), 64'(DCODED_SUB));
        check("sub_count", 64'(count), 64'd1);
        cyc(0, 0, 1, 0);
        check("sub_drained", 64'(count), 64'd0);

        cyc(1, 32'h00512023, 1, 0);
        check("empty_push_pop_count", 64'(count), 64'd1);
        cyc(1, 32'h123450B7, 1, 0);
        check("one_push_pop_count", 64'(count), 64'd1);
        check("one_push_pop_op", 64'(decoded_op), 64'(DCODED_LUI));
        cyc(1, 32'h008000EF, 0, 0);
        foreach (stream[i]) begin
            cyc(1, stream[i], 1, 0);
            check("stream_ready", 64'(instr_ready), 64'd1);
            check("stream_count", 64'(count), 64'd2);
        end
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);

        cyc(1, 32'h00000000, 0, 0);
        cyc(1, 32'h8020A1B3, 0, 0);
        check("ill0_ill", 64'(illegal), 64'd1);
        check("ill0_op", 64'(decoded_op), 64'(DCODED_ADDI));
        check("ill0_imm", 64'(imm), 64'd0);
        cyc(0, 0, 1, 0);
        check("ill1_ill", 64'(illegal), 64'd1);
        check("ill1_op", 64'(decoded_op), 64'(DCODED_ADDI));
        check("ill1_imm", 64'(imm), 64'd0);
        cyc(0, 0, 1, 0);

        foreach (mixed[i]) cyc(1, mixed[i], (i % 3) != 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);

        cyc(1, 32'h00100093, 0, 0);
        cyc(1, 32'h00200113, 0, 0);
        cyc(1, 32'h00700393, 1, 1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        cyc(0, 0, 1, 0);
        check("flush_dropped", 64'(out_valid), 64'd0);

        cyc(1, 32'h022081B3, 0, 0);
`ifdef DECODE_RV32M_EN
        check("mul_op", 64'(decoded_op), 64'(DCODED_MUL));
        check("mul_ill", 64'(illegal), 64'd0);
`else
        check("mul_op", 64'(decoded_op), 64'(DCODED_ADDI));
        check("mul_ill", 64'(illegal), 64'd1);
`endif
        cyc(0, 0, 1, 0);

        cyc(1, 32'h00C5F533, 0, 0);
        cyc(1, 32'h00412083, 0, 0);
        instr_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", 64'(count), 64'd0);
        check("async_rst_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc(1, 32'h002081B3, 0, 0);
        check("post_rst_count", 64'(count), 64'd1);
        check("post_rst_op", 64'(decoded_op), 64'(DCODED_ADD));
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
